// File: rtl/rtype_issue_ctrl_pkg.sv
// Shared constants, FSM state type and legality check for the
// R-type issue controller.
package rtype_pkg;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;

  // {funct7, funct3}
  localparam logic [9:0] F_ADD  = 10'b0000000_000;
  localparam logic [9:0] F_SLL  = 10'b0000000_001;
  localparam logic [9:0] F_SLT  = 10'b0000000_010;
  localparam logic [9:0] F_SLTU = 10'b0000000_011;
  localparam logic [9:0] F_XOR  = 10'b0000000_100;
  localparam logic [9:0] F_SRL  = 10'b0000000_101;
  localparam logic [9:0] F_OR   = 10'b0000000_110;
  localparam logic [9:0] F_AND  = 10'b0000000_111;
  localparam logic [9:0] F_SUB  = 10'b0100000_000;
  localparam logic [9:0] F_SRA  = 10'b0100000_101;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    WB
  } state_e;

  function automatic logic is_legal_rtype(
    input logic [31:0] instr
  );
    logic [9:0] f;
    f = {instr[31:25], instr[14:12]};
    if (instr[6:0] != OPC_RTYPE) return 1'b0;
    case (f)
      F_ADD, F_SLL, F_SLT, F_SLTU, F_XOR,
      F_SRL, F_OR, F_AND, F_SUB, F_SRA:
        return 1'b1;
      default:
        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rtype_issue_ctrl_fifo.sv
// Instruction FIFO with synchronous flush; pointers carry an
// extra wrap bit so full and empty are distinguishable.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          push_ok, pop_ok;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  assign push_ok = push_i && !full_o && !flush_i;
  assign pop_ok  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + PW'(1);
      if (pop_ok)  rptr_d = rptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/rtype_issue_ctrl.sv
// Queues R-type instructions, drops illegal ones, issues each to
// the ALU with a start/done handshake and writes the result back.
module rtype_issue_ctrl
  import rtype_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [31:0]      in_instr,
  output logic             in_ready,
  input  logic             flush,
  output logic             alu_start,
  output logic [31:0]      alu_instr,
  input  logic             alu_done,
  input  logic [31:0]      alu_result,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic             busy,
  output logic             timeout_err,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  state_e           state_q;
  logic [31:0]      cur_q;
  logic [TW-1:0]    wcnt_q;
  logic             alu_start_q;
  logic             rf_we_q;
  logic [4:0]       rf_waddr_q;
  logic [31:0]      rf_wdata_q;
  logic             timeout_q;
  logic [CNT_W-1:0] retired_q;
  logic [CNT_W-1:0] illegal_q;

  logic        full, empty, pop;
  logic [31:0] head;

  assign pop = (state_q == IDLE) && !empty && !flush;

  instr_fifo #(
    .DEPTH(DEPTH),
    .W    (32)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .flush_i(flush),
    .push_i (in_valid),
    .wdata_i(in_instr),
    .pop_i  (pop),
    .rdata_o(head),
    .full_o (full),
    .empty_o(empty)
  );

  assign in_ready    = !full;
  assign busy        = (state_q != IDLE) || !empty;
  assign alu_start   = alu_start_q;
  assign alu_instr   = cur_q;
  assign rf_we       = rf_we_q;
  assign rf_waddr    = rf_waddr_q;
  assign rf_wdata    = rf_wdata_q;
  assign timeout_err = timeout_q;
  assign retired_cnt = retired_q;
  assign illegal_cnt = illegal_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      wcnt_q      <= '0;
      alu_start_q <= 1'b0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      timeout_q   <= 1'b0;
      retired_q   <= '0;
      illegal_q   <= '0;
    end else begin
      alu_start_q <= 1'b0;
      rf_we_q     <= 1'b0;
      if (flush) begin
        state_q <= IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (!empty) begin
              cur_q <= head;
              if (is_legal_rtype(head)) begin
                state_q     <= ISSUE;
                alu_start_q <= 1'b1;
              end else begin
                illegal_q <= illegal_q + CNT_W'(1);
              end
            end
          end
          ISSUE: begin
            wcnt_q  <= '0;
            state_q <= WAIT;
          end
          WAIT: begin
            if (alu_done) begin
              rf_wdata_q <= alu_result;
              rf_waddr_q <= cur_q[11:7];
              rf_we_q    <= (cur_q[11:7] != 5'd0);
              state_q    <= WB;
            end else if (wcnt_q == TMAX) begin
              timeout_q <= 1'b1;
              state_q   <= IDLE;
            end else begin
              wcnt_q <= wcnt_q + TW'(1);
            end
          end
          WB: begin
            retired_q <= retired_q + CNT_W'(1);
            state_q   <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rtype_issue_ctrl.sv
// Directed bench for rtype_issue_ctrl: latency, legality,
// FIFO backpressure, timeout, flush and async reset.
module tb_rtype_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        flush;
  logic        alu_start;
  logic [31:0] alu_instr;
  logic        alu_done;
  logic [31:0] alu_result;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        busy;
  logic        timeout_err;
  logic [15:0] retired_cnt;
  logic [15:0] illegal_cnt;

  int nchk = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  rtype_issue_ctrl #(
    .DEPTH  (4),
    .TIMEOUT(16),
    .CNT_W  (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_instr   (in_instr),
    .in_ready   (in_ready),
    .flush      (flush),
    .alu_start  (alu_start),
    .alu_instr  (alu_instr),
    .alu_done   (alu_done),
    .alu_result (alu_result),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .busy       (busy),
    .timeout_err(timeout_err),
    .retired_cnt(retired_cnt),
    .illegal_cnt(illegal_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_instr   = '0;
    flush      = 1'b0;
    alu_done   = 1'b0;
    alu_result = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    nchk++;
    if (in_ready !== 1'b1) begin
      nfail++; $display("FAIL rst_in_ready got %0b exp 1", in_ready);
    end
    nchk++;
    if (busy !== 1'b0) begin
      nfail++; $display("FAIL rst_busy got %0b exp 0", busy);
    end
    nchk++;
    if (alu_start !== 1'b0 || rf_we !== 1'b0) begin
      nfail++;
      $display("FAIL rst_pulses got start=%0b we=%0b exp 0/0",
               alu_start, rf_we);
    end
    nchk++;
    if (alu_instr !== 32'h0 || rf_wdata !== 32'h0 || rf_waddr !== 5'd0) begin
      nfail++;
      $display("FAIL rst_data got %h/%h/%0d exp 0",
               alu_instr, rf_wdata, rf_waddr);
    end
    nchk++;
    if (retired_cnt !== 16'd0 || illegal_cnt !== 16'd0 || timeout_err !== 1'b0) begin
      nfail++;
      $display("FAIL rst_cnt got ret=%0d ill=%0d to=%0b exp 0",
               retired_cnt, illegal_cnt, timeout_err);
    end
  endtask

  task automatic test_add();
    do_reset();
    in_valid = 1'b1; in_instr = 32'h002081B3;
    step();
    in_valid = 1'b0;
    nchk++;
    if (alu_start !== 1'b0) begin
      nfail++; $display("FAIL add_start_early got %0b exp 0", alu_start);
    end
    step();
    nchk++;
    if (alu_start !== 1'b1 || alu_instr !== 32'h002081B3) begin
      nfail++;
      $display("FAIL add_start got %0b/%h exp 1/002081b3", alu_start, alu_instr);
    end
    step();
    nchk++;
    if (alu_start !== 1'b0) begin
      nfail++; $display("FAIL add_start_width got %0b exp 0", alu_start);
    end
    alu_done = 1'b1; alu_result = 32'd3;
    step();
    alu_done = 1'b0;
    nchk++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'd3) begin
      nfail++;
      $display("FAIL add_wb got we=%0b a=%0d d=%0d exp 1/3/3",
               rf_we, rf_waddr, rf_wdata);
    end
    step();
    nchk++;
    if (rf_we !== 1'b0 || retired_cnt !== 16'd1 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL add_retire got we=%0b ret=%0d busy=%0b exp 0/1/0",
               rf_we, retired_cnt, busy);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    in_valid = 1'b1; in_instr = 32'h00108093;
    step();
    in_instr = 32'h002081B3;
    step();
    in_valid = 1'b0;
    nchk++;
    if (illegal_cnt !== 16'd1 || alu_start !== 1'b0) begin
      nfail++;
      $display("FAIL ill_drop got ill=%0d start=%0b exp 1/0", illegal_cnt, alu_start);
    end
    step();
    nchk++;
    if (alu_start !== 1'b1 || alu_instr !== 32'h002081B3) begin
      nfail++;
      $display("FAIL ill_next_start got %0b/%h exp 1/002081b3", alu_start, alu_instr);
    end
    step();
    alu_done = 1'b1; alu_result = 32'd7;
    step();
    alu_done = 1'b0;
    nchk++;
    if (rf_we !== 1'b1 || rf_wdata !== 32'd7) begin
      nfail++; $display("FAIL ill_wb got we=%0b d=%0d exp 1/7", rf_we, rf_wdata);
    end
    step();
    nchk++;
    if (retired_cnt !== 16'd1 || illegal_cnt !== 16'd1) begin
      nfail++;
      $display("FAIL ill_cnts got ret=%0d ill=%0d exp 1/1", retired_cnt, illegal_cnt);
    end
  endtask

  task automatic test_rd_zero();
    do_reset();
    in_valid = 1'b1; in_instr = 32'h00208033;
    step();
    in_valid = 1'b0;
    step();
    nchk++;
    if (alu_start !== 1'b1) begin
      nfail++; $display("FAIL x0_start got %0b exp 1", alu_start);
    end
    step();
    alu_done = 1'b1; alu_result = 32'hDEAD;
    step();
    alu_done = 1'b0;
    nchk++;
    if (rf_we !== 1'b0) begin
      nfail++; $display("FAIL x0_we got %0b exp 0", rf_we);
    end
    step();
    nchk++;
    if (retired_cnt !== 16'd1) begin
      nfail++; $display("FAIL x0_retire got %0d exp 1", retired_cnt);
    end
  endtask

  task automatic test_fifo_full();
    do_reset();
    in_valid = 1'b1; in_instr = 32'h002081B3;
    step();
    in_instr = 32'h402081B3;
    step();
    in_instr = 32'h0020F1B3;
    step();
    in_instr = 32'h0020E1B3;
    step();
    nchk++;
    if (in_ready !== 1'b1) begin
      nfail++; $display("FAIL full_ready3 got %0b exp 1", in_ready);
    end
    in_instr = 32'h0020C1B3;
    step();
    nchk++;
    if (in_ready !== 1'b0) begin
      nfail++; $display("FAIL full_ready4 got %0b exp 0", in_ready);
    end
    in_instr = 32'h002091B3;
    repeat (14) step();
    nchk++;
    if (in_ready !== 1'b0) begin
      nfail++; $display("FAIL full_hold got %0b exp 0", in_ready);
    end
    step();
    nchk++;
    if (in_ready !== 1'b1 || alu_start !== 1'b1 || alu_instr !== 32'h402081B3) begin
      nfail++;
      $display("FAIL full_pop got rdy=%0b st=%0b i=%h exp 1/1/402081b3",
               in_ready, alu_start, alu_instr);
    end
    step();
    in_valid = 1'b0;
    nchk++;
    if (in_ready !== 1'b0) begin
      nfail++; $display("FAIL full_refill got %0b exp 0", in_ready);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    in_valid = 1'b1; in_instr = 32'h002081B3;
    step();
    in_valid = 1'b0;
    step();
    nchk++;
    if (alu_start !== 1'b1) begin
      nfail++; $display("FAIL to_start got %0b exp 1", alu_start);
    end
    repeat (16) step();
    nchk++;
    if (timeout_err !== 1'b0) begin
      nfail++; $display("FAIL to_early got %0b exp 0", timeout_err);
    end
    step();
    nchk++;
    if (timeout_err !== 1'b1 || busy !== 1'b0 || retired_cnt !== 16'd0) begin
      nfail++;
      $display("FAIL to_fire got to=%0b busy=%0b ret=%0d exp 1/0/0",
               timeout_err, busy, retired_cnt);
    end
    alu_done = 1'b1; alu_result = 32'd5;
    step();
    alu_done = 1'b0;
    nchk++;
    if (rf_we !== 1'b0 || busy !== 1'b0) begin
      nfail++; $display("FAIL to_late_done got we=%0b busy=%0b exp 0/0", rf_we, busy);
    end
    step();
    nchk++;
    if (retired_cnt !== 16'd0 || timeout_err !== 1'b1) begin
      nfail++;
      $display("FAIL to_sticky got ret=%0d to=%0b exp 0/1", retired_cnt, timeout_err);
    end
  endtask

  task automatic test_flush();
    do_reset();
    in_valid = 1'b1; in_instr = 32'h002081B3;
    step();
    in_instr = 32'h402081B3;
    step();
    in_instr = 32'h0020F1B3;
    step();
    in_instr = 32'h0020E1B3;
    step();
    in_instr = 32'h0020C1B3;
    flush = 1'b1; alu_done = 1'b1; alu_result = 32'd99;
    nchk++;
    if (busy !== 1'b1) begin
      nfail++; $display("FAIL fl_busy_before got %0b exp 1", busy);
    end
    step();
    in_valid = 1'b0; flush = 1'b0; alu_done = 1'b0;
    nchk++;
    if (rf_we !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      nfail++;
      $display("FAIL fl_after got we=%0b busy=%0b rdy=%0b exp 0/0/1",
               rf_we, busy, in_ready);
    end
    step();
    nchk++;
    if (alu_start !== 1'b0 || rf_we !== 1'b0 || busy !== 1'b0 || retired_cnt !== 16'd0) begin
      nfail++;
      $display("FAIL fl_quiet got st=%0b we=%0b busy=%0b ret=%0d exp 0/0/0/0",
               alu_start, rf_we, busy, retired_cnt);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    in_valid = 1'b1; in_instr = 32'h002081B3;
    step();
    in_instr = 32'h402081B3;
    step();
    in_valid = 1'b0;
    step();
    #2 rst = 1'b1;
    #1;
    nchk++;
    if (busy !== 1'b0 || alu_instr !== 32'h0 || in_ready !== 1'b1) begin
      nfail++;
      $display("FAIL arst got busy=%0b i=%h rdy=%0b exp 0/0/1",
               busy, alu_instr, in_ready);
    end
    step();
    rst = 1'b0;
    alu_done = 1'b1; alu_result = 32'd1;
    step();
    alu_done = 1'b0;
    step();
    nchk++;
    if (rf_we !== 1'b0 || retired_cnt !== 16'd0 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL arst_after got we=%0b ret=%0d busy=%0b exp 0/0/0",
               rf_we, retired_cnt, busy);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_illegal();
    test_rd_zero();
    test_fifo_full();
    test_timeout();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/rtype_issue_ctrl.md
Name: rtype_issue_ctrl

Overview:
- Sequencer that sits in front of the R-type ALU/register-file datapath.
- Buffers incoming 32-bit instructions in a small FIFO, decodes each one and rejects illegal encodings.
- Issues legal instructions one at a time to the ALU with a start/done handshake, then performs the register-file writeback.
- Provides flush, timeout detection, and retire/illegal counters for debug.

Parameters:
- DEPTH, 4, instruction FIFO entries (power of two, ≥2).
- TIMEOUT, 16, max cycles in WAIT without alu_done before abort.
- CNT_W, 16, width of the retire and illegal counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  instruction offered.
- in_instr  in  32  RV32 instruction word.
- in_ready  out  1  FIFO can accept; combinational !full.
- flush  in  1  drop queue and any in-flight instruction.
- alu_start  out  1  one-cycle issue pulse to the ALU.
- alu_instr  out  32  instruction presented to the ALU; stable from ISSUE through WAIT.
- alu_done  in  1  ALU result valid; earliest one cycle after alu_start.
- alu_result  in  32  ALU result.
- rf_we  out  1  register-file write enable, one cycle.
- rf_waddr  out  5  destination register (instr[11:7]).
- rf_wdata  out  32  writeback data.
- busy  out  1  FSM not in IDLE, or FIFO non-empty.
- timeout_err  out  1  sticky; cleared only by rst.
- retired_cnt  out  CNT_W  legal instructions completed; wraps.
- illegal_cnt  out  CNT_W  instructions dropped as illegal; wraps.

Behaviour:
- Clock and reset: single clock clk; reset rst is asynchronous and active-high.
- Reset values:
  - FIFO empty, FSM in IDLE.
  - All outputs 0, except in_ready=1.
- FIFO:
  - Push when in_valid && in_ready.
  - Pop only in IDLE when non-empty.
  - Push and pop in the same cycle are both performed; occupancy is unchanged.
  - When full, in_ready=0 and any offered instruction is not taken; no overwrite.
  - Pointers wrap modulo DEPTH.
- Legality: opcode==7'b0110011 and {funct7,funct3} in the set 000_0000_000..000_0000_111, 010_0000_000, 010_0000_101.
- FSM states: IDLE, ISSUE, WAIT, WB.
  - IDLE, FIFO non-empty: pop head into cur_instr.
    - Illegal: illegal_cnt+1, stay IDLE; next pop possible the following cycle.
    - Legal: go to ISSUE.
  - ISSUE: alu_start=1 for exactly one cycle, alu_instr=cur_instr, clear the wait counter; go to WAIT.
  - WAIT:
    - On alu_done: capture alu_result into rf_wdata, go to WB.
    - If the wait counter reaches TIMEOUT: set timeout_err, go to IDLE with no writeback and no retire.
  - WB:
    - rf_we=1 only if rd!=0; rf_waddr=rd.
    - retired_cnt+1 regardless of rd; go to IDLE.
- Latency: push at cycle N into an empty FIFO with the FSM idle gives:
  - pop at N+1;
  - alu_start at N+2;
  - with alu_done at N+3, rf_we at N+4.
  - Throughput is at most one instruction per 4 cycles.
- alu_done outside WAIT is ignored.
- flush:
  - Takes effect at the next edge: FIFO emptied, FSM forced to IDLE, no rf_we, counters untouched.
  - flush has priority over a same-cycle push (push is discarded), alu_done and timeout.
- Asynchronous rst mid-operation: immediate return to reset values; a pending ALU operation is abandoned.

Decomposition:
- Package rtype_pkg:
  - OPC_RTYPE constant;
  - funct10 constants for the 10 supported operations;
  - state enum IDLE/ISSUE/WAIT/WB;
  - function is_legal_rtype(instr).
- Sub-module instr_fifo (DEPTH-parameterised synchronous FIFO with full/empty/flush).
- FSM, counters and writeback registers stay in the top level.

Test Plan:
- Reset then push ADD x3,x1,x2 (0x002081B3) at N, alu_done at N+3 with alu_result=3 -> alu_start at N+2, rf_we at N+4 with rf_waddr=3 and rf_wdata=3, retired_cnt=1.
- Push addi 0x00108093 followed by 0x002081B3 -> illegal_cnt=1, no rf_we for the first, the second retires normally, retired_cnt=1.
- Push ADD x0,x1,x2 (0x00208033) -> alu_start pulses, rf_we stays 0, retired_cnt=1.
- Hold alu_done=0, push 5 instructions back-to-back with DEPTH=4 -> in_ready=0 after 4 entries are stored; the 5th is taken only after the FSM's first pop.
- alu_done never asserted -> timeout_err=1 exactly TIMEOUT cycles after entering WAIT, FSM in IDLE, retired_cnt=0.
- 3 instructions queued, first in WAIT, assert flush together with alu_done -> no rf_we, FIFO empty, busy=0 next cycle, retired_cnt unchanged.
